// File: rtl/systolic_feeder_if.sv
// Operand/lane bundle between the operand loader, the feeder and the systolic array.
// The slave modport is the feeder's view; the master modport drives it.
interface systolic_feeder_if #(
  parameter int SIZE   = 4,
  parameter int I_BITS = 8
);
  logic                          i_valid;
  logic                          o_ready;
  logic [SIZE*SIZE*I_BITS-1:0]   i_a_mat;
  logic [SIZE*SIZE*I_BITS-1:0]   i_b_mat;
  logic [SIZE*I_BITS-1:0]        o_a_full;
  logic [SIZE*I_BITS-1:0]        o_b_full;
  logic                          o_array_reset;
  logic [SIZE*SIZE-1:0]          i_finish;
  logic                          o_busy;
  logic                          o_done;
  logic                          o_error;

  modport slave (
    input  i_valid, i_a_mat, i_b_mat, i_finish,
    output o_ready, o_a_full, o_b_full, o_array_reset, o_busy, o_done, o_error
  );

  modport master (
    output i_valid, i_a_mat, i_b_mat, i_finish,
    input  o_ready, o_a_full, o_b_full, o_array_reset, o_busy, o_done, o_error
  );
endinterface

// File: rtl/systolic_feeder.sv
// Captures an A/B operand pair, pulses the array reset, streams both matrices
// onto the lane buses with diagonal skew, then waits for all PE finish flags.
module systolic_feeder #(
  parameter int SIZE      = 4,
  parameter int I_BITS    = 8,
  parameter int DRAIN_MAX = 4*SIZE
) (
  input  logic               i_clock,
  input  logic               i_reset,
  systolic_feeder_if.slave   bus
);
  localparam int TW = $clog2(2*SIZE);
  localparam int DW = $clog2(DRAIN_MAX+1);
  localparam int MW = SIZE*SIZE*I_BITS;
  localparam logic [TW-1:0] T_LAST = TW'(2*SIZE-2);
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            error_q, error_d;
  logic [MW-1:0]   a_q, a_d;
  logic [MW-1:0]   b_q, b_d;

  // Counters default to zero so each one restarts on entry to its state.
  always_comb begin
    state_d = state_q;
    t_d     = '0;
    drain_d = '0;
    error_d = error_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          state_d = S_CLEAR;
          error_d = 1'b0;
          a_d     = bus.i_a_mat;
          b_d     = bus.i_b_mat;
        end
      end
      S_CLEAR: state_d = S_STREAM;
      S_STREAM: begin
        if (t_q == T_LAST) state_d = S_DRAIN;
        else               t_d     = t_q + 1'b1;
      end
      S_DRAIN: begin
        if (&bus.i_finish) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
          if (drain_d == D_LAST) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      drain_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      drain_q <= drain_d;
      error_q <= error_d;
    end
  end

  // Operand storage is only ever observed while streaming, so it needs no reset.
  always_ff @(posedge i_clock) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  // Lane k carries row k of A and column k of B, delayed by k cycles.
  always_comb begin
    bus.o_a_full = '0;
    bus.o_b_full = '0;
    if (state_q == S_STREAM) begin
      for (int k = 0; k < SIZE; k++) begin
        if ((int'(t_q) >= k) && (int'(t_q) - k < SIZE)) begin
          bus.o_a_full[k*I_BITS +: I_BITS] = a_q[(k*SIZE + int'(t_q) - k)*I_BITS +: I_BITS];
          bus.o_b_full[k*I_BITS +: I_BITS] = b_q[((int'(t_q) - k)*SIZE + k)*I_BITS +: I_BITS];
        end
      end
    end
  end

  assign bus.o_ready       = (state_q == S_IDLE);
  assign bus.o_busy        = (state_q != S_IDLE);
  assign bus.o_array_reset = (state_q == S_CLEAR);
  assign bus.o_done        = (state_q == S_DONE);
  assign bus.o_error       = error_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized scoreboard bench for systolic_feeder: the driver predicts each run's
// skewed lane frames and completion timing; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_systolic_feeder;
  localparam int S  = 4;
  localparam int IB = 8;
  localparam int DM = 4*S;
  localparam int NF = 2*S-1;
  localparam int LW = S*IB;
  localparam int NP = S*S;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   held = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_feeder_if #(.SIZE(S), .I_BITS(IB)) bus ();

  systolic_feeder #(.SIZE(S), .I_BITS(IB), .DRAIN_MAX(DM)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    int clear_cyc;
    int done_cyc;
    bit err;
  } run_t;

  run_t           run_q[$];
  logic [LW-1:0]  exp_a_q[$];
  logic [LW-1:0]  exp_b_q[$];
  logic [IB-1:0]  ma[S][S];
  logic [IB-1:0]  mb[S][S];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, req);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s @cyc %0d: got event, want none", name, cyc);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int            stream_left;
    bit            have_cur;
    bit            exp_err;
    run_t          cur;
    logic [LW-1:0] ea, eb;
    stream_left = 0;
    have_cur    = 1'b0;
    exp_err     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run_q.delete();
        exp_a_q.delete();
        exp_b_q.delete();
        stream_left = 0;
        have_cur    = 1'b0;
        exp_err     = 1'b0;
      end else begin
        if (stream_left > 0) begin
          ea = exp_a_q.pop_front();
          eb = exp_b_q.pop_front();
          check("a_lanes", 32'(bus.o_a_full), 32'(ea));
          check("b_lanes", 32'(bus.o_b_full), 32'(eb));
          stream_left--;
        end else begin
          check("a_lanes_zero", 32'(bus.o_a_full), 32'(0));
          check("b_lanes_zero", 32'(bus.o_b_full), 32'(0));
        end
        if (bus.o_array_reset) begin
          if (run_q.size() == 0) begin
            fail_evt("unexpected_clear");
          end else begin
            cur         = run_q.pop_front();
            have_cur    = 1'b1;
            exp_err     = 1'b0;
            stream_left = NF;
            check("clear_cycle", 32'(cyc), 32'(cur.clear_cyc));
          end
        end
        if (bus.o_done) begin
          if (!have_cur) begin
            fail_evt("unexpected_done");
          end else begin
            check("done_cycle", 32'(cyc), 32'(cur.done_cyc));
            exp_err  = cur.err;
            have_cur = 1'b0;
          end
        end
        check("error_flag", 32'(bus.o_error), 32'(exp_err));
        check("ready_vs_busy", 32'(bus.o_ready), 32'(!bus.o_busy));
      end
    end
  end

  // ---------------- reference model ----------------
  // Each lane is a stream: k leading zeros, then the row (A) or column (B), then zeros.
  task automatic push_expected(input int n, input int done_cyc, input bit err);
    logic [IB-1:0] sa[S][NF];
    logic [IB-1:0] sb[S][NF];
    logic [LW-1:0] fa, fb;
    run_t          r;
    for (int k = 0; k < S; k++) begin
      int p;
      p = 0;
      for (int j = 0; j < k; j++) begin sa[k][p] = '0; sb[k][p] = '0; p++; end
      for (int j = 0; j < S; j++) begin sa[k][p] = ma[k][j]; sb[k][p] = mb[j][k]; p++; end
      while (p < NF) begin sa[k][p] = '0; sb[k][p] = '0; p++; end
    end
    for (int t = 0; t < NF; t++) begin
      for (int k = 0; k < S; k++) begin
        fa[k*IB +: IB] = sa[k][t];
        fb[k*IB +: IB] = sb[k][t];
      end
      exp_a_q.push_back(fa);
      exp_b_q.push_back(fb);
    end
    r.clear_cyc = n + 1;
    r.done_cyc  = done_cyc;
    r.err       = err;
    run_q.push_back(r);
  endtask

  task automatic drive_mats();
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        bus.i_a_mat[(r*S+c)*IB +: IB] = ma[r][c];
        bus.i_b_mat[(r*S+c)*IB +: IB] = mb[r][c];
      end
  endtask

  task automatic set_random();
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        ma[r][c] = IB'($urandom);
        mb[r][c] = IB'($urandom);
      end
    drive_mats();
  endtask

  function automatic logic [NP-1:0] rand_partial();
    logic [NP-1:0] v;
    v = '1;
    v[$urandom_range(0, NP-1)] = 1'b0;
    return v;
  endfunction

  task automatic check_reset_vals();
    check("rst_ready", 32'(bus.o_ready), 32'(1));
    check("rst_busy", 32'(bus.o_busy), 32'(0));
    check("rst_done", 32'(bus.o_done), 32'(0));
    check("rst_error", 32'(bus.o_error), 32'(0));
    check("rst_array_reset", 32'(bus.o_array_reset), 32'(0));
    check("rst_a_lanes", 32'(bus.o_a_full), 32'(0));
    check("rst_b_lanes", 32'(bus.o_b_full), 32'(0));
  endtask

  // mode 0: finish all-ones from CLEAR on; 1: finish rises at DRAIN offset f;
  // 2: finish never complete (timeout). abort_at>0 resets at accept+abort_at.
  task automatic do_run(input int mode, input int f, input logic [NP-1:0] part,
                        input bit hold_next, input int abort_at);
    int n, done_exp, fin_from;
    bit err_exp, got, acc;
    bus.i_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.o_ready) begin acc = 1'b1; n = cyc; break; end
    end
    if (!acc) begin
      check("accept_timeout", 32'(0), 32'(1));
      bus.i_valid = 1'b0;
      held = 1'b0;
      return;
    end
    if (mode == 2) begin
      done_exp = n + 2*S + 1 + DM;
      err_exp  = 1'b1;
    end else begin
      done_exp = n + 2*S + 2 + ((mode == 0) ? 0 : f);
      err_exp  = 1'b0;
    end
    fin_from = (mode == 0) ? n + 1 : n + 2*S + 1 + f;
    push_expected(n, done_exp, err_exp);
    @(posedge clk); #1;
    if (hold_next) begin
      set_random();
      held = 1'b1;
    end else begin
      bus.i_valid = 1'b0;
      bus.i_a_mat = {NP{IB'($urandom)}};
      bus.i_b_mat = {NP{IB'($urandom)}};
      held = 1'b0;
    end
    got = 1'b0;
    for (int i = 1; i < 2*S + DM + 10; i++) begin
      if (mode != 2 && (n + i) >= fin_from) bus.i_finish = '1;
      else                                  bus.i_finish = part;
      if (abort_at == i) begin
        rst = 1'b1;
        bus.i_valid = 1'b0;
        held = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_vals();
        return;
      end
      @(negedge clk);
      if (bus.o_done) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!got) check("done_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    bus.i_finish = NP'($urandom);
  endtask

  initial begin : driver
    bus.i_valid  = 1'b0;
    bus.i_a_mat  = '0;
    bus.i_b_mat  = '0;
    bus.i_finish = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;

    // Known matrices, finish already present on the first DRAIN cycle.
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        ma[r][c] = IB'(r*S + c + 1);
        mb[r][c] = IB'(8'h40 + r*S + c);
      end
    drive_mats();
    do_run(1, 0, rand_partial(), 1'b0, 0);

    // Finish stuck at FFFE -> timeout with error, valid held with new matrices.
    set_random();
    do_run(2, 0, 16'hFFFE, 1'b1, 0);
    // Back-to-back: held matrices stream, finish high from CLEAR onward.
    do_run(0, 0, rand_partial(), 1'b0, 0);
    // Finish arrives on the last allowed DRAIN cycle.
    set_random();
    do_run(1, DM-1, rand_partial(), 1'b0, 0);
    // Reset during STREAM t=1, then a normal run.
    set_random();
    do_run(1, 2, rand_partial(), 1'b0, 3);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    set_random();
    do_run(1, 1, rand_partial(), 1'b0, 0);

    for (int it = 0; it < 30; it++) begin
      int mode;
      mode = $urandom_range(0, 5);
      mode = (mode <= 1) ? 0 : (mode == 5) ? 2 : 1;
      if (!held) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        set_random();
      end
      do_run(mode, $urandom_range(0, DM-1), rand_partial(), 1'($urandom_range(0, 1)), 0);
    end

    bus.i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of run, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
